// File: rtl/u8dbg_pkg.sv
// Shared definitions for the nX-u8 debug host bridge: FSM encodings, frame layout, response bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package u8dbg_pkg;

  // Main sequencer states (4-bit encoding).
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_GET_HI = 4'd1,
    S_GET_LO = 4'd2,
    S_ISSUE  = 4'd3,
    S_WAIT   = 4'd4,
    S_SEND   = 4'd5
  } state_e;

  // Command byte0 layout: {reg[6:0], dir}.
  localparam int DIR_BIT = 0;
  localparam int REG_MSB = 7;
  localparam int REG_LSB = 1;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

  // Timeout counter width; a 1-cycle timeout still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/u8dbg_resp_tx.sv
// Two-entry response serialiser: loaded with one or two bytes, presents them in order on a valid/ready port.
// Latency: first byte valid the cycle after load_i; second byte valid the cycle after the first is accepted.
// Backpressure: tx_data_o/tx_valid_o hold until tx_ready_i; load_i is only issued while the serialiser is empty.
// Ports: clk/rst_n; load_i/two_i/b0_i/b1_i load side; tx_data_o/tx_valid_o/tx_ready_i host side;
//        done_o pulses on the edge where the final byte is accepted.
module u8dbg_resp_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       two_i,
  input  logic [7:0] b0_i,
  input  logic [7:0] b1_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       done_o
);

  logic [7:0] data_q;
  logic [7:0] hold_q;
  logic       vld_q;
  logic       pend_q;
  logic       accept;

  assign accept = vld_q && tx_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      hold_q <= 8'h00;
      vld_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if (load_i) begin
      data_q <= b0_i;
      hold_q <= b1_i;
      vld_q  <= 1'b1;
      pend_q <= two_i;
    end else if (accept) begin
      if (pend_q) begin
        data_q <= hold_q;
        pend_q <= 1'b0;
      end else begin
        // Park the data bus at zero while idle so it matches the reset view.
        data_q <= 8'h00;
        vld_q  <= 1'b0;
      end
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = vld_q;
  assign done_o     = accept && !pend_q;

endmodule

// File: rtl/u8dbg_host_bridge.sv
// Host-side sequencer for the nX-u8 debug serial engine: parses 1/3-byte frames, issues one engine transaction, streams the response.
// Latency: dbg_start 1 cycle after the last frame byte; first response byte 1 cycle after dbg_trigger (NAK TIMEOUT_CYCLES+1 after start).
// Backpressure: rx_ready low from issue until the last response byte is accepted; response bytes hold until tx_ready.
// Ports: clk/rst_n; rx_* host command stream; tx_* host response stream; dbg_* engine interface;
//        busy (not idle) and err_timeout (sticky until the next accepted command byte).
module u8dbg_host_bridge
  import u8dbg_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_start,
  output logic [6:0]  dbg_reg,
  output logic        dbg_dir,
  output logic [15:0] dbg_wdata,
  input  logic [15:0] dbg_rdata,
  input  logic        dbg_trigger,
  output logic        busy,
  output logic        err_timeout
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q,    state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              start_q,    start_d;
  logic [6:0]        reg_q,      reg_d;
  logic              dir_q,      dir_d;
  logic [15:0]       wdata_q,    wdata_d;
  logic              busy_q,     busy_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              rx_acc;
  logic              in_wait;
  logic              resp_load;
  logic              resp_two;
  logic [7:0]        resp_b0;
  logic              tx_done;

  assign rx_acc  = rx_valid && rx_ready_q;
  assign in_wait = (state_q == S_WAIT);

  // Trigger has priority over the terminal count, so a coincident trigger still returns data.
  assign resp_load = in_wait && (dbg_trigger || (cnt_q == CNT_LAST));
  assign resp_two  = dbg_trigger && dir_q;
  assign resp_b0   = dbg_trigger ? (dir_q ? dbg_rdata[15:8] : ACK_BYTE) : NAK_BYTE;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    dir_d   = dir_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          reg_d   = rx_data[REG_MSB:REG_LSB];
          dir_d   = rx_data[DIR_BIT];
          err_d   = 1'b0;
          state_d = rx_data[DIR_BIT] ? S_ISSUE : S_GET_HI;
        end
      end
      S_GET_HI: begin
        if (rx_acc) begin
          wdata_d[15:8] = rx_data;
          state_d       = S_GET_LO;
        end
      end
      S_GET_LO: begin
        if (rx_acc) begin
          wdata_d[7:0] = rx_data;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (dbg_trigger) begin
          state_d = S_SEND;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    start_d    = (state_d == S_ISSUE);
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_GET_HI) || (state_d == S_GET_LO);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      reg_q      <= 7'h00;
      dir_q      <= 1'b0;
      wdata_q    <= 16'h0000;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      start_q    <= start_d;
      reg_q      <= reg_d;
      dir_q      <= dir_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  u8dbg_resp_tx u_resp_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (resp_load),
    .two_i      (resp_two),
    .b0_i       (resp_b0),
    .b1_i       (dbg_rdata[7:0]),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (tx_done)
  );

  assign rx_ready    = rx_ready_q;
  assign dbg_start   = start_q;
  assign dbg_reg     = reg_q;
  assign dbg_dir     = dir_q;
  assign dbg_wdata   = wdata_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: doc/u8dbg_host_bridge.md
Name: u8dbg_host_bridge

Overview:
- Upstream sequencer for the nX-u8 debug serial engine.
- Consumes a byte stream from the host link (UART or USB FIFO side) and parses 1- or 3-byte command frames.
- Issues exactly one debug-register transaction per frame by driving start, register, direction and write data into the serial engine.
- Returns the result to the host as a response byte stream: 2 data bytes for a read, ACK for a write, NAK on timeout.

Parameters:
- TIMEOUT_CYCLES, 4096: clk cycles allowed between the start pulse and trigger before the transaction is abandoned.
- ACK_BYTE, 8'hA5: response byte sent after a completed write.
- NAK_BYTE, 8'hEE: response byte sent after a timeout (read or write).

Ports:
- clk  in  1  core clock; the same clock as the serial engine (2x debug bit rate).
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  host command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data this cycle.
- tx_data  out  8  response byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host link accepts tx_data.
- dbg_start  out  1  one-cycle transaction start pulse to the engine.
- dbg_reg  out  7  debug register address.
- dbg_dir  out  1  1 = read, 0 = write.
- dbg_wdata  out  16  write data to the engine.
- dbg_rdata  in  16  read data from the engine; valid in the cycle dbg_trigger = 1.
- dbg_trigger  in  1  engine completion pulse (one cycle).
- busy  out  1  high in every state except S_IDLE.
- err_timeout  out  1  sticky timeout flag; cleared by reset or by the next accepted command byte.

Behaviour:
- Reset (async assert, sync release):
  - State is S_IDLE.
  - rx_ready=0, tx_valid=0, tx_data=0, dbg_start=0, dbg_reg=0, dbg_dir=0, dbg_wdata=0, busy=0, err_timeout=0, timeout counter=0.
  - rx_ready rises in the first cycle after reset release.
- Byte handshake: a byte transfers when valid && ready are both high on a clk edge. tx_data/tx_valid stay stable until accepted.
- Frame format:
  - Byte0 is {reg[6:0], dir}.
  - dir=1 (read): the frame is complete after byte0.
  - dir=0 (write): byte1 = wdata[15:8], byte2 = wdata[7:0].
- States:
  - S_IDLE: rx_ready=1. On accept, latch dbg_reg/dbg_dir, clear err_timeout. dir=1 goes to S_ISSUE; dir=0 goes to S_GET_HI.
  - S_GET_HI: rx_ready=1. On accept, latch dbg_wdata[15:8], go to S_GET_LO.
  - S_GET_LO: rx_ready=1. On accept, latch dbg_wdata[7:0], go to S_ISSUE.
  - S_ISSUE: dbg_start=1 for exactly this one cycle. Load the counter with 0. Go to S_WAIT.
  - S_WAIT: counter increments each cycle.
    - dbg_trigger=1: capture dbg_rdata into the response register. Go to S_SEND_HI if dir=1, else S_SEND_ACK.
    - Otherwise, counter == TIMEOUT_CYCLES-1: set err_timeout, go to S_SEND_NAK.
    - Trigger and terminal count in the same cycle: trigger wins.
  - S_SEND_HI: tx_data = rdata[15:8], tx_valid=1. On accept go to S_SEND_LO.
  - S_SEND_LO: tx_data = rdata[7:0], tx_valid=1. On accept go to S_IDLE.
  - S_SEND_ACK / S_SEND_NAK: tx_data = ACK_BYTE / NAK_BYTE, tx_valid=1. On accept go to S_IDLE.
- rx_ready=0 in S_ISSUE, S_WAIT and all S_SEND_* states. Host bytes arriving then are back-pressured, never dropped.
- dbg_reg, dbg_dir and dbg_wdata are registered and held constant from S_ISSUE until the bridge returns to S_IDLE. The engine samples them throughout the transfer.
- dbg_start is never asserted outside S_ISSUE. Back-to-back frames therefore always have at least one dbg_start=0 cycle between pulses, so the engine sees a clean re-arm.
- dbg_trigger outside S_WAIT is ignored.
- Latency: the read response byte0 is valid 1 cycle after the trigger edge. The minimum frame-to-start time is 1 cycle after the last frame byte is accepted.
- Reset mid-operation: the FSM aborts immediately and outputs return to reset values. Any in-flight engine transfer is not cancelled; the host must resync by waiting at least TIMEOUT_CYCLES before reissuing.
- Counter width is clog2(TIMEOUT_CYCLES). It saturates and never wraps.

Decomposition:
- Shared package u8dbg_pkg holds:
  - state localparam encodings (4-bit);
  - frame field positions (DIR_BIT=0, REG_MSB=7, REG_LSB=1);
  - ACK/NAK default values.
- One natural sub-module, u8dbg_resp_tx: a 2-entry response byte serialiser with valid/ready. It is loaded with {byte_count, bytes} and frees the main FSM from per-byte send states. Inline implementation is also acceptable.

Test Plan:
- Read, immediate host: rx 8'h0B (reg 5, read); engine model returns 16'hBEEF with trigger 70 cycles after start -> exactly one dbg_start pulse with dbg_reg=5, dbg_dir=1; tx stream 8'hBE then 8'hEF; busy falls after the second byte.
- Write: rx 8'h0A, 8'h12, 8'h34 -> dbg_start once with dbg_reg=5, dbg_dir=0, dbg_wdata=16'h1234 held stable until trigger; tx 8'hA5.
- Timeout with TIMEOUT_CYCLES=16 and no trigger -> tx 8'hEE exactly 17 cycles after the dbg_start cycle; err_timeout=1; the next accepted rx byte clears it.
- Back-pressure: tx_ready held low 20 cycles during a read response -> tx_data stays 8'hBE and valid; rx_valid asserted meanwhile sees rx_ready=0; no byte lost; order preserved.
- Trigger coincident with the terminal count -> data response sent, not NAK, err_timeout=0.
- rst_n pulsed low during S_WAIT -> all outputs at reset values on the same edge; a fresh read frame afterwards completes normally.
